tlp_cpl_tx: RTL and testbench
=============================

TLP_CPL_TX -- requirements
Module: tlp_cpl_tx

Interface
REQ-001 SHALL have parameter COMPLETER_ID, default 16'h0100, bus/dev/func placed in completion DW1[31:16].
REQ-002 SHALL have port tlp_clk  input  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  completion request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_requester_id  input  16  requester ID from the MemRd TLP.
REQ-007 SHALL have port req_tag  input  8  tag from the MemRd TLP.
REQ-008 SHALL have port req_lower_addr  input  7  address bits [6:0] of the read.
REQ-009 SHALL have port req_len_dw  input  4  payload length in DWs; legal 1..8.
REQ-010 SHALL have port req_data  input  256  payload; DW n at bits [32n+31:32n].
REQ-011 SHALL have port tl_tx_wait  input  1  sink backpressure; beat not consumed while high.
REQ-012 SHALL have ports tl_tx_sop and tl_tx_eop  output  1 each  first/last beat of TLP.
REQ-013 SHALL have port tl_tx_data  output  256  beat data; DW0 in bits [31:0].
REQ-014 SHALL have port tl_tx_valid  output  8  per-DW valid; all zero means no beat.
REQ-015 SHALL have port cpl_count  output  16  number of TLPs fully sent, wraps at 16'hFFFF.
REQ-016 SHALL have port drop_count  output  8  illegal-length requests dropped, saturates at 8'hFF.

Function
REQ-017 SHALL implement states IDLE, BEAT0, BEAT1; req_ready = 1 only in IDLE.
REQ-018 SHALL, on accept in IDLE with legal length, register all request fields and enter BEAT0 next cycle.
REQ-019 SHALL, on accept with req_len_dw = 0 or 9..15, send nothing, stay IDLE, increment drop_count.
REQ-020 SHALL build header DW0 = {8'h4A, 14'h0, 6'b0, len[3:0]} (CplD, 3DW, length field = len).
REQ-021 SHALL build DW1 = {COMPLETER_ID, 3'b000 status, 1'b0 BCM, byte_count = len*4 as 12 bits}.
REQ-022 SHALL build DW2 = {req_requester_id, req_tag, 1'b0, req_lower_addr}.
REQ-023 SHALL in BEAT0 drive sop=1, DW0-2 = header, DW3..7 = payload DW0..4, valid bits [2+len:0] set (len<=5) else 8'hFF.
REQ-024 SHALL in BEAT0 drive eop=1 iff len<=5; in BEAT1 drive sop=0, eop=1, DW0..len-6 = payload DW5..len-1, valid low (len-5) bits set.
REQ-025 SHALL hold all tl_tx_* outputs stable while tl_tx_wait=1; a beat advances only on a cycle with tl_tx_wait=0.
REQ-026 SHALL move BEAT0->IDLE (len<=5) or BEAT0->BEAT1 (len>=6) on advance; BEAT1->IDLE on advance.
REQ-027 SHALL drive tl_tx_valid=0, sop=0, eop=0 in IDLE; unused DW lanes of tl_tx_data SHALL be zero.
REQ-028 SHALL increment cpl_count on the cycle the eop beat advances.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, enter IDLE, clear tl_tx_data, tl_tx_valid, sop, eop, cpl_count, drop_count, abandoning any in-flight TLP.
REQ-030 SHALL hold req_ready=0 during any cycle rst=1.

Configuration
REQ-031 SHALL, with CPL_TX_UR_EN defined, add input req_ur (1 bit); accepted request with req_ur=1 sends single-beat Cpl: DW0[31:24]=8'h0A, length 0, status 3'b001, byte_count 0, valid 8'h07, sop=eop=1, length check bypassed.
REQ-032 SHALL, without CPL_TX_UR_EN, have no req_ur port and generate only successful CplD.

Structure
REQ-033 SHALL place Fmt/Type constants (8'h4A, 8'h0A), status codes and the state encoding in shared package edu_tlp_pkg.
REQ-034 SHALL instantiate one combinational sub-module tlp_cpl_hdr producing the three header DWs.

Verification
REQ-035 SHALL test: req len=1, id 16'h0010, tag 8'h05, addr 7'h04, wait=0 -> one beat, sop=eop=1, valid 8'h0F, DW0 32'h4A000001, DW1 32'h01000004, DW2 32'h00100504.
REQ-036 SHALL test: len=8 -> beat0 valid 8'hFF eop=0, beat1 valid 8'h07 with payload DW5..7, cpl_count +1 after beat1.
REQ-037 SHALL test: len=6 with tl_tx_wait high 3 cycles during beat0 -> beat0 outputs unchanged 4 cycles, beat1 valid 8'h01 follows.
REQ-038 SHALL test: len=0 and len=9 -> no beat, drop_count=2, req_ready returns 1 next cycle.
REQ-039 SHALL test: rst=1 during BEAT1 -> next cycle valid=8'h00, counters 0, IDLE, req_ready=1 after rst drops.
REQ-040 SHALL test (CPL_TX_UR_EN): req_ur=1, len=3 -> single beat valid 8'h07, DW0 32'h0A000000, DW1[15:13]=3'b001.

Source files
------------

// File: rtl/edu_tlp_pkg.sv
// Shared TLP completion constants, FSM encoding and lane helpers.
// Optional unsupported-request path is selected by CPL_TX_UR_EN.
package edu_tlp_pkg;

  localparam logic [7:0] FMT_CPLD = 8'h4A;
  localparam logic [7:0] FMT_CPL  = 8'h0A;
  localparam logic [2:0] CPL_SC   = 3'b000;
  localparam logic [2:0] CPL_UR   = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } cpl_state_e;

  function automatic logic [7:0] dw_mask(
    input logic [3:0] n
  );
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return (n >= 4'd8) ? 8'hFF : m[7:0];
  endfunction

  // Zero every DW lane whose valid bit is clear.
  function automatic logic [255:0] lane_mask(
    input logic [255:0] d,
    input logic [7:0]   v
  );
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[32*i +: 32] = v[i] ? d[32*i +: 32] : 32'h0;
    return r;
  endfunction

  function automatic logic len_ok(
    input logic [3:0] len
  );
    return (len != 4'd0) && (len <= 4'd8);
  endfunction

endpackage

// File: rtl/tlp_cpl_tx_if.sv
// Request and transmit-link signals of the completion engine.
// req_ur exists only when CPL_TX_UR_EN is defined.
interface tlp_cpl_tx_if;

  logic         req_valid;
  logic         req_ready;
  logic [15:0]  req_requester_id;
  logic [7:0]   req_tag;
  logic [6:0]   req_lower_addr;
  logic [3:0]   req_len_dw;
  logic [255:0] req_data;
`ifdef CPL_TX_UR_EN
  logic         req_ur;
`endif
  logic         tl_tx_wait;
  logic         tl_tx_sop;
  logic         tl_tx_eop;
  logic [255:0] tl_tx_data;
  logic [7:0]   tl_tx_valid;

  modport master (
`ifdef CPL_TX_UR_EN
    input  req_ur,
`endif
    input  req_valid,
    output req_ready,
    input  req_requester_id,
    input  req_tag,
    input  req_lower_addr,
    input  req_len_dw,
    input  req_data,
    input  tl_tx_wait,
    output tl_tx_sop,
    output tl_tx_eop,
    output tl_tx_data,
    output tl_tx_valid
  );

  modport slave (
`ifdef CPL_TX_UR_EN
    output req_ur,
`endif
    output req_valid,
    input  req_ready,
    output req_requester_id,
    output req_tag,
    output req_lower_addr,
    output req_len_dw,
    output req_data,
    output tl_tx_wait,
    input  tl_tx_sop,
    input  tl_tx_eop,
    input  tl_tx_data,
    input  tl_tx_valid
  );

endinterface

// File: rtl/tlp_cpl_hdr.sv
// Combinational 3DW completion header builder.
// ur selects the Cpl/UR header (used only with CPL_TX_UR_EN).
module tlp_cpl_hdr
  import edu_tlp_pkg::*;
#(
  parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
  input  logic        ur,
  input  logic [3:0]  len,
  input  logic [15:0] requester_id,
  input  logic [7:0]  tag,
  input  logic [6:0]  lower_addr,
  output logic [31:0] dw0,
  output logic [31:0] dw1,
  output logic [31:0] dw2
);

  always_comb begin
    dw0 = {FMT_CPLD, 14'h0, 6'h0, len};
    dw1 = {COMPLETER_ID, CPL_SC, 1'b0,
           6'h0, len, 2'b00};
    if (ur) begin
      dw0 = {FMT_CPL, 24'h0};
      dw1 = {COMPLETER_ID, CPL_UR, 1'b0, 12'h0};
    end
    dw2 = {requester_id, tag, 1'b0, lower_addr};
  end

endmodule

// File: rtl/tlp_cpl_tx.sv
// Completion TLP transmitter: one MemRd completion per request.
// Define CPL_TX_UR_EN to add the req_ur unsupported-request path.
module tlp_cpl_tx
  import edu_tlp_pkg::*;
#(
  parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
  input  logic          tlp_clk,
  input  logic          rst,
  tlp_cpl_tx_if.master  bus,
  output logic [15:0]   cpl_count,
  output logic [7:0]    drop_count
);

  cpl_state_e  state;
  logic [3:0]  len_q;
  logic [95:0] tail_q;
  logic        ur;
  logic        accept;
  logic        adv;
  logic [31:0] h0, h1, h2;
  logic [7:0]  b0_valid;
  logic [255:0] b0_data;

`ifdef CPL_TX_UR_EN
  assign ur = bus.req_ur;
`else
  assign ur = 1'b0;
`endif

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept = bus.req_valid && bus.req_ready;
  assign adv    = (state != IDLE) && !bus.tl_tx_wait;

  tlp_cpl_hdr #(
    .COMPLETER_ID(COMPLETER_ID)
  ) u_hdr (
    .ur           (ur),
    .len          (bus.req_len_dw),
    .requester_id (bus.req_requester_id),
    .tag          (bus.req_tag),
    .lower_addr   (bus.req_lower_addr),
    .dw0          (h0),
    .dw1          (h1),
    .dw2          (h2)
  );

  always_comb begin
    b0_valid = 8'hFF;
    if (ur)
      b0_valid = 8'h07;
    else if (bus.req_len_dw <= 4'd5)
      b0_valid = dw_mask(bus.req_len_dw + 4'd3);
    b0_data = lane_mask(
      {bus.req_data[159:0], h2, h1, h0},
      b0_valid);
  end

  always_ff @(posedge tlp_clk) begin
    if (rst) begin
      state           <= IDLE;
      len_q           <= 4'd0;
      tail_q          <= 96'h0;
      bus.tl_tx_sop   <= 1'b0;
      bus.tl_tx_eop   <= 1'b0;
      bus.tl_tx_data  <= 256'h0;
      bus.tl_tx_valid <= 8'h00;
      cpl_count       <= 16'h0;
      drop_count      <= 8'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (ur || len_ok(bus.req_len_dw)) begin
              state           <= BEAT0;
              len_q           <= bus.req_len_dw;
              tail_q          <= bus.req_data[255:160];
              bus.tl_tx_sop   <= 1'b1;
              bus.tl_tx_eop   <= ur ||
                                 (bus.req_len_dw <= 4'd5);
              bus.tl_tx_data  <= b0_data;
              bus.tl_tx_valid <= b0_valid;
            end else if (drop_count != 8'hFF) begin
              drop_count <= drop_count + 8'd1;
            end
          end
        end
        BEAT0: begin
          if (adv && bus.tl_tx_eop) begin
            state           <= IDLE;
            bus.tl_tx_sop   <= 1'b0;
            bus.tl_tx_eop   <= 1'b0;
            bus.tl_tx_data  <= 256'h0;
            bus.tl_tx_valid <= 8'h00;
            cpl_count       <= cpl_count + 16'd1;
          end else if (adv) begin
            // Remaining payload DW5.. starts at lane 0.
            state           <= BEAT1;
            bus.tl_tx_sop   <= 1'b0;
            bus.tl_tx_eop   <= 1'b1;
            bus.tl_tx_valid <= dw_mask(len_q - 4'd5);
            bus.tl_tx_data  <= lane_mask(
              {160'h0, tail_q},
              dw_mask(len_q - 4'd5));
          end
        end
        BEAT1: begin
          if (adv) begin
            state           <= IDLE;
            bus.tl_tx_sop   <= 1'b0;
            bus.tl_tx_eop   <= 1'b0;
            bus.tl_tx_data  <= 256'h0;
            bus.tl_tx_valid <= 8'h00;
            cpl_count       <= cpl_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_cpl_tx.sv
// Randomized bench for tlp_cpl_tx with a DW-list reference model.
// Adds unsupported-request checks when CPL_TX_UR_EN is defined.
module tb_tlp_cpl_tx;

  localparam logic [15:0] CID = 16'h0100;

  logic        tlp_clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpl_count;
  logic [7:0]  drop_count;

  tlp_cpl_tx_if bus();

  tlp_cpl_tx #(
    .COMPLETER_ID(CID)
  ) dut (
    .tlp_clk    (tlp_clk),
    .rst        (rst),
    .bus        (bus),
    .cpl_count  (cpl_count),
    .drop_count (drop_count)
  );

  always #5 tlp_clk = ~tlp_clk;

  typedef struct {
    logic         sop;
    logic         eop;
    logic [7:0]   valid;
    logic [255:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] cpl_exp = 16'h0;
  logic [7:0]  drop_exp = 8'h0;
  bit          force_wait = 1'b0;
  int          wait_pct = 0;

  task automatic chk(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Whole TLP as a flat DW list, then cut into 8-DW beats.
  function automatic void build_tlp(
    input logic         ur,
    input logic [3:0]   len,
    input logic [15:0]  rid,
    input logic [7:0]   tag,
    input logic [6:0]   addr,
    input logic [255:0] data
  );
    logic [31:0] dw[16];
    int n;
    int l;
    l = int'(len);
    for (int i = 0; i < 16; i++) dw[i] = 32'h0;
    if (ur) begin
      dw[0] = 32'h0A000000;
      dw[1] = {CID, 3'b001, 13'h0};
      n = 3;
    end else begin
      dw[0] = 32'h4A000000 + 32'(l);
      dw[1] = {CID, 4'h0, 12'(l * 4)};
      n = 3 + l;
      for (int i = 0; i < l; i++)
        dw[3+i] = data[32*i +: 32];
    end
    dw[2] = {rid, tag, 1'b0, addr};
    for (int b = 0; b * 8 < n; b++) begin
      beat_t e;
      e.sop = (b == 0);
      e.eop = ((b + 1) * 8 >= n);
      e.valid = 8'h00;
      e.data = 256'h0;
      for (int k = 0; k < 8; k++) begin
        if (b * 8 + k < n) begin
          e.valid[k] = 1'b1;
          e.data[32*k +: 32] = dw[b*8+k];
        end
      end
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge tlp_clk) begin
    #2;
    bus.tl_tx_wait = force_wait ||
      ($urandom_range(0, 99) < wait_pct);
  end

  always @(negedge tlp_clk) begin
    logic ur_in;
`ifdef CPL_TX_UR_EN
    ur_in = bus.req_ur;
`else
    ur_in = 1'b0;
`endif
    chk("req_ready", bus.req_ready,
        !rst && (exp_q.size() == 0));
    chk("cpl_count", cpl_count, cpl_exp);
    chk("drop_count", drop_count, drop_exp);
    if (bus.tl_tx_valid == 8'h00) begin
      chk("idle_out",
          {bus.tl_tx_sop, bus.tl_tx_eop, bus.tl_tx_data},
          258'h0);
    end else if (exp_q.size() == 0) begin
      chk("unexp_beat", bus.tl_tx_valid, 8'h00);
    end else begin
      chk("sop", bus.tl_tx_sop, exp_q[0].sop);
      chk("eop", bus.tl_tx_eop, exp_q[0].eop);
      chk("valid", bus.tl_tx_valid, exp_q[0].valid);
      chk("data", bus.tl_tx_data, exp_q[0].data);
    end
    if (rst) begin
      exp_q.delete();
      cpl_exp = 16'h0;
      drop_exp = 8'h0;
    end else begin
      if (bus.tl_tx_valid != 8'h00 && !bus.tl_tx_wait &&
          exp_q.size() > 0) begin
        if (exp_q[0].eop) cpl_exp++;
        void'(exp_q.pop_front());
      end
      if (bus.req_valid && bus.req_ready) begin
        if (ur_in || (bus.req_len_dw >= 4'd1 &&
                      bus.req_len_dw <= 4'd8))
          build_tlp(ur_in, bus.req_len_dw,
                    bus.req_requester_id, bus.req_tag,
                    bus.req_lower_addr, bus.req_data);
        else if (drop_exp != 8'hFF)
          drop_exp++;
      end
    end
  end

  task automatic cyc();
    @(posedge tlp_clk);
    #1;
  endtask

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic send(
    input logic         ur,
    input logic [3:0]   len,
    input logic [15:0]  rid,
    input logic [7:0]   tag,
    input logic [6:0]   addr,
    input logic [255:0] data
  );
    int t;
    t = 0;
    while (!bus.req_ready && t < 500) begin
      cyc();
      t++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 1'b0, 1'b1);
    end else begin
`ifdef CPL_TX_UR_EN
      bus.req_ur = ur;
`endif
      bus.req_requester_id = rid;
      bus.req_tag = tag;
      bus.req_lower_addr = addr;
      bus.req_len_dw = len;
      bus.req_data = data;
      bus.req_valid = 1'b1;
      cyc();
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic wait_beat();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge tlp_clk);
      if (bus.tl_tx_valid != 8'h00) ok = 1'b1;
    end
    if (!ok) chk("beat_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    logic [255:0] d;
    logic [255:0] snap;
    logic [7:0]   snap_v;
    logic [3:0]   len;
    logic         ur;
    bus.req_valid = 1'b0;
    bus.req_requester_id = 16'h0;
    bus.req_tag = 8'h0;
    bus.req_lower_addr = 7'h0;
    bus.req_len_dw = 4'h0;
    bus.req_data = 256'h0;
`ifdef CPL_TX_UR_EN
    bus.req_ur = 1'b0;
`endif
    bus.tl_tx_wait = 1'b0;
    repeat (3) cyc();
    @(negedge tlp_clk);
    chk("rst_valid", bus.tl_tx_valid, 8'h00);
    chk("rst_ready", bus.req_ready, 1'b0);
    cyc();
    rst = 1'b0;

    d = rand_data();
    send(1'b0, 4'd1, 16'h0010, 8'h05, 7'h04, d);
    wait_beat();
    chk("t1_valid", bus.tl_tx_valid, 8'h0F);
    chk("t1_sop_eop", {bus.tl_tx_sop, bus.tl_tx_eop}, 2'b11);
    chk("t1_dw0", bus.tl_tx_data[31:0], 32'h4A000001);
    chk("t1_dw1", bus.tl_tx_data[63:32], 32'h01000004);
    chk("t1_dw2", bus.tl_tx_data[95:64], 32'h00100504);
    chk("t1_dw3", bus.tl_tx_data[127:96], d[31:0]);

    d = rand_data();
    send(1'b0, 4'd8, 16'hBEEF, 8'h11, 7'h7F, d);
    wait_beat();
    chk("t2_b0_valid", bus.tl_tx_valid, 8'hFF);
    chk("t2_b0_eop", bus.tl_tx_eop, 1'b0);
    chk("t2_b0_pl4", bus.tl_tx_data[255:224], d[159:128]);
    @(negedge tlp_clk);
    chk("t2_b1_valid", bus.tl_tx_valid, 8'h07);
    chk("t2_b1_sop_eop", {bus.tl_tx_sop, bus.tl_tx_eop}, 2'b01);
    chk("t2_b1_pl", bus.tl_tx_data[95:0], d[255:160]);
    chk("t2_b1_zero", bus.tl_tx_data[255:96], 160'h0);
    @(negedge tlp_clk);
    chk("t2_cpl", cpl_count, 16'd2);

    d = rand_data();
    send(1'b0, 4'd6, 16'h1234, 8'h22, 7'h10, d);
    force_wait = 1'b1;
    @(negedge tlp_clk);
    snap = bus.tl_tx_data;
    snap_v = bus.tl_tx_valid;
    chk("t3_b0_valid", snap_v, 8'hFF);
    repeat (2) begin
      @(negedge tlp_clk);
      chk("t3_hold_data", bus.tl_tx_data, snap);
      chk("t3_hold_valid", bus.tl_tx_valid, snap_v);
    end
    cyc();
    force_wait = 1'b0;
    @(negedge tlp_clk);
    chk("t3_hold_data", bus.tl_tx_data, snap);
    @(negedge tlp_clk);
    chk("t3_b1_valid", bus.tl_tx_valid, 8'h01);
    chk("t3_b1_pl5", bus.tl_tx_data[31:0], d[191:160]);
    @(negedge tlp_clk);

    send(1'b0, 4'd0, 16'h0001, 8'h01, 7'h01, rand_data());
    @(negedge tlp_clk);
    chk("t4_drop1", drop_count, 8'd1);
    chk("t4_ready1", bus.req_ready, 1'b1);
    send(1'b0, 4'd9, 16'h0002, 8'h02, 7'h02, rand_data());
    @(negedge tlp_clk);
    chk("t4_drop2", drop_count, 8'd2);
    chk("t4_ready2", bus.req_ready, 1'b1);
    chk("t4_nobeat", bus.tl_tx_valid, 8'h00);

    send(1'b0, 4'd8, 16'h5555, 8'h33, 7'h20, rand_data());
    cyc();
    force_wait = 1'b1;
    @(negedge tlp_clk);
    chk("t5_in_b1", {bus.tl_tx_sop, bus.tl_tx_eop}, 2'b01);
    cyc();
    rst = 1'b1;
    @(negedge tlp_clk);
    chk("t5_rst_ready", bus.req_ready, 1'b0);
    cyc();
    rst = 1'b0;
    force_wait = 1'b0;
    @(negedge tlp_clk);
    chk("t5_valid", bus.tl_tx_valid, 8'h00);
    chk("t5_cpl", cpl_count, 16'd0);
    chk("t5_drop", drop_count, 8'd0);
    chk("t5_ready", bus.req_ready, 1'b1);

`ifdef CPL_TX_UR_EN
    send(1'b1, 4'd3, 16'h0042, 8'h07, 7'h08, rand_data());
    wait_beat();
    chk("t6_valid", bus.tl_tx_valid, 8'h07);
    chk("t6_sop_eop", {bus.tl_tx_sop, bus.tl_tx_eop}, 2'b11);
    chk("t6_dw0", bus.tl_tx_data[31:0], 32'h0A000000);
    chk("t6_status", bus.tl_tx_data[47:45], 3'b001);
    @(negedge tlp_clk);
`endif

    wait_pct = 30;
    for (int i = 0; i < 300; i++) begin
      len = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0)
        len = 4'($urandom_range(1, 8));
      ur = 1'b0;
`ifdef CPL_TX_UR_EN
      ur = ($urandom_range(0, 7) == 0);
`endif
      send(ur, len, 16'($urandom), 8'($urandom),
           7'($urandom), rand_data());
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
    end

    wait_pct = 0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++)
      @(negedge tlp_clk);
    chk("drain", exp_q.size(), 0);
    @(negedge tlp_clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
